// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared types and widths for the core-side APU request/response initiator.
package cv32e40p_apu_core_pkg;

  localparam int unsigned APU_NARGS_CPU    = 3;
  localparam int unsigned APU_WOP_CPU      = 6;
  localparam int unsigned APU_NDSFLAGS_CPU = 15;
  localparam int unsigned APU_NUSFLAGS_CPU = 5;
  localparam int unsigned APU_WADDR_W      = 6;

  typedef struct packed {
    logic [APU_NARGS_CPU-1:0][31:0] operands;
    logic [APU_WOP_CPU-1:0]         op;
    logic [APU_NDSFLAGS_CPU-1:0]    flags;
    logic [APU_WADDR_W-1:0]         waddr;
  } apu_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } apu_state_e;

endpackage

// File: rtl/cv32e40p_apu_tag_fifo.sv
// In-order FIFO of destination register addresses for granted APU operations.
module cv32e40p_apu_tag_fifo
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [APU_WADDR_W-1:0] data_i,
  output logic [APU_WADDR_W-1:0] head_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [APU_WADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   do_push;
  logic                   do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_apu_initiator.sv
// Core-side APU master: registers requests, tracks outstanding tags, registers writeback.
// Optional sticky exception flags: CV32E40P_APU_STICKY_FLAGS_EN.
module cv32e40p_apu_initiator
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [APU_NARGS_CPU-1:0][31:0]       req_operands_i,
  input  logic [APU_WOP_CPU-1:0]               req_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]          req_flags_i,
  input  logic [APU_WADDR_W-1:0]               req_waddr_i,
  output logic                                 apu_req_o,
  input  logic                                 apu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]       apu_operands_o,
  output logic [APU_WOP_CPU-1:0]               apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]          apu_flags_o,
  input  logic                                 apu_rvalid_i,
  input  logic [31:0]                          apu_rdata_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]          apu_rflags_i,
  output logic                                 wb_valid_o,
  output logic [APU_WADDR_W-1:0]               wb_waddr_o,
  output logic [31:0]                          wb_wdata_o,
  output logic                                 busy_o,
  output logic [APU_NUSFLAGS_CPU-1:0]          fflags_o,
  input  logic                                 fflags_clr_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(DEPTH + 2);

  apu_state_e             state_q;
  apu_req_t               req_q;
  logic                   wb_valid_q;
  logic [APU_WADDR_W-1:0] wb_waddr_q;
  logic [31:0]            wb_wdata_q;

  logic [CNT_W-1:0]       cnt;
  logic [OCC_W-1:0]       occ;
  logic [APU_WADDR_W-1:0] fifo_head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   accept;
  logic                   gnt_fire;
  logic                   bypass;
  logic                   rsp_hit;
  logic                   push;
  logic                   pop;

  assign occ         = OCC_W'(cnt) + OCC_W'(state_q == REQ);
  assign req_ready_o = rst_ni && ((state_q == IDLE) || apu_gnt_i) && (occ < OCC_W'(DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign gnt_fire    = (state_q == REQ) && apu_gnt_i;

  // A zero-latency response to the op being granted this cycle never enters the FIFO.
  assign bypass  = apu_rvalid_i && fifo_empty && gnt_fire;
  assign rsp_hit = apu_rvalid_i && (!fifo_empty || gnt_fire);
  assign push    = gnt_fire && !bypass;
  assign pop     = apu_rvalid_i && !fifo_empty;

  cv32e40p_apu_tag_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (req_q.waddr),
    .head_o  (fifo_head),
    .count_o (cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= REQ;
            req_q   <= '{req_operands_i, req_op_i, req_flags_i, req_waddr_i};
          end
        end
        REQ: begin
          if (apu_gnt_i) begin
            if (accept) begin
              req_q <= '{req_operands_i, req_op_i, req_flags_i, req_waddr_i};
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
    end else begin
      wb_valid_q <= rsp_hit;
      if (rsp_hit) begin
        wb_waddr_q <= fifo_empty ? req_q.waddr : fifo_head;
        wb_wdata_q <= apu_rdata_i;
      end
    end
  end

  assign apu_req_o      = (state_q == REQ);
  assign apu_operands_o = req_q.operands;
  assign apu_op_o       = req_q.op;
  assign apu_flags_o    = req_q.flags;
  assign wb_valid_o     = wb_valid_q;
  assign wb_waddr_o     = wb_waddr_q;
  assign wb_wdata_o     = wb_wdata_q;
  assign busy_o         = (state_q == REQ) || (cnt != '0) || wb_valid_q;

`ifdef CV32E40P_APU_STICKY_FLAGS_EN
  logic [APU_NUSFLAGS_CPU-1:0] fflags_q;

  // Clear takes effect first so same-cycle new flags survive.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fflags_q <= '0;
    end else if (fflags_clr_i || apu_rvalid_i) begin
      fflags_q <= (fflags_clr_i ? '0 : fflags_q) | (apu_rvalid_i ? apu_rflags_i : '0);
    end
  end

  assign fflags_o = fflags_q;
`else
  logic unused_flags;
  assign unused_flags = ^{fflags_clr_i, apu_rflags_i};
  assign fflags_o     = '0;
`endif

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(apu_rvalid_i && fifo_empty && !gnt_fire));

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && fifo_full));

endmodule

// File: doc/cv32e40p_apu_initiator.md
# cv32e40p_apu_initiator

Core-side master for the APU request/response protocol. Takes decoded FP operations from the core's execute stage, registers them onto the APU request channel (`apu_req_o`/`apu_gnt_i`), and tracks outstanding operations' destination registers in an in-order FIFO. It pairs each `apu_rvalid_i` response with its register address and presents a registered writeback to the register file. The FPU-side responder sits on the other end of the same interface.

## Interface
- `DEPTH`, 2: max outstanding operations (granted plus pending), ≥1
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; one clock, synchronous, active-low
- `req_valid_i`  in  1  core has an operation
- `req_ready_o`  out  1  operation accepted this cycle when high with `req_valid_i`
- `req_operands_i`  in  APU_NARGS_CPU×32  operands
- `req_op_i`  in  APU_WOP_CPU  {vec, op_mod, op}
- `req_flags_i`  in  APU_NDSFLAGS_CPU  {int_fmt, src_fmt, dst_fmt, rnd_mode}
- `req_waddr_i`  in  6  destination register (bit 5 = FP regfile)
- `apu_req_o`  out  1  APU request
- `apu_gnt_i`  in  1  APU grant
- `apu_operands_o`, `apu_op_o`, `apu_flags_o`  out  as request  held request payload
- `apu_rvalid_i`  in  1  response valid (no backpressure)
- `apu_rdata_i`  in  32  result
- `apu_rflags_i`  in  APU_NUSFLAGS_CPU  exception flags
- `wb_valid_o`  out  1  writeback strobe
- `wb_waddr_o`  out  6  writeback address
- `wb_wdata_o`  out  32  writeback data
- `busy_o`  out  1  pending or outstanding operation exists
- `fflags_o`  out  APU_NUSFLAGS_CPU  sticky accumulated flags
- `fflags_clr_i`  in  1  clear sticky flags

## Operation
- FSM states: IDLE (no pending request), REQ (payload held, `apu_req_o`=1).
- IDLE→REQ on accept. REQ→IDLE on `apu_gnt_i` with no new accept. REQ→REQ on grant plus same-cycle accept (back-to-back).
- `occ = cnt_q + (state==REQ)`. `req_ready_o = rst_ni && (state==IDLE || apu_gnt_i) && occ < DEPTH`. A same-cycle pop does not free a slot; there is no rvalid→ready path.
- Payload and waddr stay stable while in REQ; only the accept path writes them.
- Grant pushes the held waddr into the FIFO. `apu_rvalid_i` pops the FIFO head.
- Bypass: rvalid with FIFO empty and same-cycle grant uses the held waddr; no push, no pop.
- Simultaneous push and pop with FIFO non-empty: count unchanged, both pointers advance, wrap at DEPTH-1.
- rvalid with empty FIFO and no grant is a protocol error: ignored, flagged by assertion.
- Responses return in issue order (responder contract).

## Timing
- Accept at cycle t → `apu_req_o`=1 at t+1.
- `apu_rvalid_i` at t → `wb_valid_o`/`wb_waddr_o`/`wb_wdata_o` at t+1, for one cycle.
- Reset values: `apu_req_o`=0, `req_ready_o`=0 during reset, `wb_valid_o`=0, `wb_waddr_o`=0, `wb_wdata_o`=0, `busy_o`=0, `fflags_o`=0, FIFO empty, state IDLE.
- Reset mid-operation discards the pending request and all outstanding entries. Any later stray rvalid falls under the protocol-error rule.
- `busy_o = (state==REQ) || cnt_q!=0 || wb_valid_o`.

## Configuration
- `CV32E40P_APU_STICKY_FLAGS_EN` defined:
  - `fflags_o` ORs in `apu_rflags_i` on every rvalid.
  - `fflags_clr_i` zeroes it; clear and set in the same cycle keeps the new flags.
- Undefined: `fflags_o` is tied to 0 and `fflags_clr_i` is ignored. `apu_rflags_i` is still not propagated to writeback.

## Structure
- In `cv32e40p_apu_core_pkg`:
  - `apu_req_t` struct (operands, op, flags, waddr)
  - `APU_WADDR_W`=6
- Sub-module `cv32e40p_apu_tag_fifo`: DEPTH-entry waddr FIFO with push, pop, head, count, empty, and full outputs.

## Test plan
- Single op, immediate grant, rvalid 3 cycles later with rdata=0x3F800000, waddr=0x21 → `wb_valid_o` once at rvalid+1 with those values; `busy_o` drops next cycle.
- Grant held low 4 cycles → `apu_req_o` stays high and payload is unchanged; `req_ready_o`=0 throughout.
- DEPTH=2, three back-to-back requests with grant always high and no rvalid → third is stalled until after the first rvalid. Writebacks appear in order with waddrs 0x01, 0x02, 0x03.
- Zero-latency responder (rvalid same cycle as grant, FIFO empty) → bypass writes back the held waddr; FIFO count stays 0.
- Sticky flags: rflags 0x01, then 0x04 → `fflags_o`=0x05. Clear and rflags 0x02 in the same cycle → 0x02. With the macro undefined → always 0.
- Reset asserted with 2 outstanding plus 1 pending → next cycle all outputs are at reset values and a new request is accepted normally.
